regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Write-back arbiter and scoreboard for the integer register file's single write port. Up to NREQ functional units (ALU, load unit, mul/div, CSR) present write-back requests over valid/ready; the block grants one per cycle round-robin and drives the register file write port from registered outputs. It also keeps a per-register busy scoreboard so issue logic can detect read-after-write hazards until the data is actually in the register file.

## Interface
- NREQ, 4, number of write-back requesters (2..8)
- XLEN, 32, data width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request valid, one bit per requester
- req_rd  in  NREQ*5  destination register; requester i uses bits [5i+4:5i]
- req_data  in  NREQ*XLEN  write data; requester i uses bits [XLEN*i+XLEN-1:XLEN*i]
- req_ready  out  NREQ  grant, combinational, at most one bit set
- rf_we  out  1  register file write enable (drives data_valid)
- rf_rd  out  5  register file destination index
- rf_data  out  XLEN  register file write data
- sb_set_valid  in  1  issue logic marks a destination pending
- sb_set_rd  in  5  destination being marked pending
- flush  in  1  synchronous pipeline flush
- sb_busy  out  32  bit r = 1 when register r has an outstanding write

## Operation
- Handshake: transfer on req_valid[i] & req_ready[i] at a rising edge. Requester holds valid, rd and data stable until it is granted; valid never drops before a grant.
- Arbitration: round-robin pointer ptr (log2 NREQ bits). Grant the first valid requester scanning ptr, ptr+1, ... modulo NREQ. After any grant, ptr <= granted index + 1 mod NREQ. No grant leaves ptr unchanged.
- req_ready is zero when flush = 1. No transfer takes place in a flush cycle.
- Output stage: on a transfer, rf_rd <= req_rd[g], rf_data <= req_data[g], and rf_we <= (req_rd[g] != 0). With no transfer, rf_we <= 0 and rf_rd/rf_data hold their values.
- x0 requests: granted and consume an arbitration slot. They never assert rf_we and never touch the scoreboard.
- Scoreboard set: at the edge, if sb_set_valid & sb_set_rd != 0, then busy[sb_set_rd] <= 1.
- Scoreboard clear: at the edge, if rf_we = 1, then busy[rf_rd] <= 0. This clear uses the registered write, so a bit falls on the same edge the register file captures the data.
- Set and clear hitting the same register on the same edge: set wins, because a newer producer has been issued.
- flush: all busy bits go to 0 at the edge, and this overrides any set. An rf_we already registered still completes its write. ptr is unchanged.
- busy[0] is constant 0.

## Timing
- Reset values: rf_we = 0, rf_rd = 0, rf_data = 0, sb_busy = 0, ptr = 0. req_ready is combinational from req_valid, ptr and flush.
- Reset asserted mid-operation: all state clears immediately. A pending rf_we is dropped.
- Latency: a transfer at edge N gives rf_we = 1 during cycle N..N+1. The register file writes at edge N+1, and the busy bit clears at edge N+1. Reads after edge N+1 return the new data.
- Throughput: one write per cycle, back-to-back. With k requesters continuously valid, each is granted exactly once every k cycles.
- Worst-case wait for a valid requester: NREQ-1 cycles without flush.

## Test plan
- Reset: hold rst = 0 with random inputs. Expect rf_we = 0, sb_busy = 0, req_ready = 0 through the reset. After release with only req_valid = 4'b0001, expect req_ready = 4'b0001.
- Single write: req 2 with rd = 5, data = 0xDEADBEEF, after sb_set_rd = 5 the cycle before. Expect grant, then rf_we = 1, rf_rd = 5, rf_data = 0xDEADBEEF for one cycle. busy[5] goes 1 -> 0 at the write edge.
- Round-robin fairness: all four valid continuously from ptr = 0. Expect grant order 0, 1, 2, 3, 0, 1. Then drop req 1 and expect order 2, 3, 0, 2.
- x0 write: req 0 with rd = 0, data = 0x1234. Expect req_ready = 1 and ptr to advance, with rf_we staying 0 and sb_busy unchanged.
- Set/clear collision: rf_we = 1, rf_rd = 7 registered while sb_set_valid = 1, sb_set_rd = 7. Expect busy[7] = 1 after the edge. The same setup with sb_set_rd = 8 gives busy[7] = 0 and busy[8] = 1.
- Flush: busy = 0x0000_00F0 and req_valid = 4'b1111 with flush = 1. Expect req_ready = 0, sb_busy = 0 after the edge, and an already-registered rf_we still asserted for its cycle.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the integer register file, plus a busy scoreboard.
// Latency: a grant at edge N drives rf_we/rf_rd/rf_data during N..N+1; busy clears at N+1.
// Backpressure: req_ready is one-hot grant, zero during flush or reset; losers hold their requests.
module regfile_wb_arbiter #(
  parameter int NREQ = 4,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*5-1:0]    req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_we,
  output logic [4:0]           rf_rd,
  output logic [XLEN-1:0]      rf_data,
  input  logic                 sb_set_valid,
  input  logic [4:0]           sb_set_rd,
  input  logic                 flush,
  output logic [31:0]          sb_busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_data_q, rf_data_d;
  logic [31:0]     busy_q, busy_d;

  logic [PW:0]     cand;
  logic [PW:0]     ptr_nxt;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_found;
  logic            xfer;
  logic [4:0]      gnt_rd;
  logic [XLEN-1:0] gnt_data;

  // Round-robin scan starting at ptr; first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(NREQ)) begin
        cand = cand - (PW+1)'(NREQ);
      end
      if (!gnt_found && req_valid[cand[PW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[PW-1:0];
      end
    end
  end

  // Grant is suppressed during flush and while reset is held, so nothing is
  // handed a slot that the output stage cannot capture.
  always_comb begin
    xfer      = gnt_found & ~flush & rst;
    req_ready = xfer ? (NREQ'(1) << gnt_idx) : '0;
  end

  // Select the granted requester's destination and data.
  always_comb begin
    gnt_rd   = '0;
    gnt_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == PW'(i)) begin
        gnt_rd   = req_rd[i*5 +: 5];
        gnt_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Pointer moves past the winner; idle or flushed cycles leave it alone.
  always_comb begin
    ptr_d   = ptr_q;
    ptr_nxt = {1'b0, gnt_idx} + (PW+1)'(1);
    if (ptr_nxt >= (PW+1)'(NREQ)) begin
      ptr_nxt = '0;
    end
    if (xfer) begin
      ptr_d = ptr_nxt[PW-1:0];
    end
  end

  // Output stage: x0 transfers take a slot but never raise the write enable.
  always_comb begin
    rf_we_d   = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (xfer) begin
      rf_we_d   = (gnt_rd != 5'd0);
      rf_rd_d   = gnt_rd;
      rf_data_d = gnt_data;
    end
  end

  // Scoreboard: registered write clears, a new issue sets (set wins), flush wipes all.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) begin
      busy_d[rf_rd_q] = 1'b0;
    end
    if (sb_set_valid && (sb_set_rd != 5'd0)) begin
      busy_d[sb_set_rd] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  // State registers; reset drops any pending write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q     <= '0;
      rf_we_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
      busy_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      rf_we_q   <= rf_we_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
      busy_q    <= busy_d;
    end
  end

  assign rf_we   = rf_we_q;
  assign rf_rd   = rf_rd_q;
  assign rf_data = rf_data_q;
  assign sb_busy = busy_q;

endmodule
